// File: rtl/demo_scene_sequencer.sv
// demo_scene_sequencer: frame-synchronous scheduler for the vga_control byte.
// Steps through a fixed scene table, dwelling FRAMES_PER_SCENE frames per scene,
// with pause/single-step and a manual passthrough mode. Every visible change
// lands on a frame_start so the pixel block never tears mid-frame.
//
// Build option: define DEMO_SEQ_BLANK_EN to insert BLANK_FRAMES black frames
// between scenes (blank=1 while the gap runs).
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   MANUAL  | vga_control follows manual_ctrl at each frame_start
//   PLAY    | counting frames, advancing scenes automatically
//   PAUSED  | frame count frozen; a step pulse advances one scene
//   BLANK   | inter-scene black gap (DEMO_SEQ_BLANK_EN builds only)

module demo_scene_sequencer #(
    parameter int NUM_SCENES       = 11,
    parameter int FRAMES_PER_SCENE = 120,
    parameter int BLANK_FRAMES     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic       run,
    input  logic       pause,
    input  logic       step,
    input  logic [7:0] manual_ctrl,
    output logic [7:0] vga_control,
    output logic [3:0] scene_idx,
    output logic       scene_change,
    output logic       blank
);

    typedef enum logic [1:0] {ST_MANUAL, ST_PLAY, ST_PAUSED, ST_BLANK} state_t;

    localparam logic [7:0] FPS_LAST   = 8'(FRAMES_PER_SCENE - 1);
    localparam logic [3:0] SCENE_LAST = 4'(NUM_SCENES - 1);

    // Out-of-range parameters would silently break the wrap and terminal counts.
    if (NUM_SCENES < 2 || NUM_SCENES > 16) begin : g_bad_num_scenes
        $error("NUM_SCENES out of range 2..16");
    end
    if (FRAMES_PER_SCENE < 1 || FRAMES_PER_SCENE > 255) begin : g_bad_fps
        $error("FRAMES_PER_SCENE out of range 1..255");
    end
    if (BLANK_FRAMES < 1 || BLANK_FRAMES > 255) begin : g_bad_blank
        $error("BLANK_FRAMES out of range 1..255");
    end

    // Bit4 stays 0 so the pixel block never runs its own loop; bit5 alternates the sprite.
    function automatic logic [7:0] scene_entry(input logic [3:0] i);
        return {2'b00, i[0], 1'b0, i};
    endfunction

    state_t     state_q, state_d;
    logic [7:0] vga_d;
    logic [3:0] scene_d, scene_next;
    logic [7:0] frame_cnt, frame_cnt_d;
    logic       change_d;
    logic       step_pending;
    logic       advance;

`ifdef DEMO_SEQ_BLANK_EN
    localparam logic [7:0] BLANK_LAST = 8'(BLANK_FRAMES - 1);
    logic [7:0] blank_cnt, blank_cnt_d;
    logic       blank_q, blank_d;
    logic       ret_paused, ret_paused_d;
    assign blank = blank_q;
`else
    assign blank = 1'b0;
`endif

    assign scene_next = (scene_idx == SCENE_LAST) ? 4'd0 : scene_idx + 4'd1;

    // Next-state and output decisions; nothing moves unless frame_start is sampled.
    always_comb begin
        state_d     = state_q;
        vga_d       = vga_control;
        scene_d     = scene_idx;
        frame_cnt_d = frame_cnt;
        change_d    = 1'b0;
        advance     = 1'b0;
`ifdef DEMO_SEQ_BLANK_EN
        blank_cnt_d  = blank_cnt;
        blank_d      = blank_q;
        ret_paused_d = ret_paused;
`endif
        if (frame_start) begin
            case (state_q)
                ST_MANUAL: begin
                    vga_d = manual_ctrl;
                    if (run) begin
                        state_d     = ST_PLAY;
                        vga_d       = scene_entry(scene_idx);
                        frame_cnt_d = 8'd0;
                        change_d    = 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (!run) begin
                        state_d = ST_MANUAL;
                        vga_d   = manual_ctrl;
                    end else if (pause) begin
                        state_d = ST_PAUSED;
                    end else if (frame_cnt == FPS_LAST) begin
                        frame_cnt_d = 8'd0;
                        advance     = 1'b1;
                    end else begin
                        frame_cnt_d = frame_cnt + 8'd1;
                    end
                end
                ST_PAUSED: begin
                    if (!run) begin
                        state_d = ST_MANUAL;
                        vga_d   = manual_ctrl;
                    end else if (!pause) begin
                        state_d = ST_PLAY;
                    end else if (step_pending || step) begin
                        frame_cnt_d = 8'd0;
                        advance     = 1'b1;
                    end
                end
`ifdef DEMO_SEQ_BLANK_EN
                ST_BLANK: begin
                    if (!run) begin
                        state_d = ST_MANUAL;
                        blank_d = 1'b0;
                        vga_d   = manual_ctrl;
                    end else if (blank_cnt == BLANK_LAST) begin
                        vga_d       = scene_entry(scene_idx);
                        blank_d     = 1'b0;
                        change_d    = 1'b1;
                        blank_cnt_d = 8'd0;
                        state_d     = ret_paused ? ST_PAUSED : ST_PLAY;
                    end else begin
                        blank_cnt_d = blank_cnt + 8'd1;
                    end
                end
`endif
                default: state_d = ST_MANUAL;
            endcase

            if (advance) begin
                scene_d = scene_next;
`ifdef DEMO_SEQ_BLANK_EN
                // Old vga_control stays on the bus while blank masks it.
                blank_d      = 1'b1;
                blank_cnt_d  = 8'd0;
                ret_paused_d = (state_q == ST_PAUSED);
                state_d      = ST_BLANK;
`else
                vga_d    = scene_entry(scene_next);
                change_d = 1'b1;
`endif
            end
        end
    end

    // State and registered outputs; a step is remembered until the next frame boundary.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_MANUAL;
            vga_control  <= 8'h00;
            scene_idx    <= 4'd0;
            frame_cnt    <= 8'd0;
            step_pending <= 1'b0;
            scene_change <= 1'b0;
`ifdef DEMO_SEQ_BLANK_EN
            blank_cnt  <= 8'd0;
            blank_q    <= 1'b0;
            ret_paused <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            vga_control  <= vga_d;
            scene_idx    <= scene_d;
            frame_cnt    <= frame_cnt_d;
            scene_change <= change_d;
            step_pending <= frame_start ? 1'b0 : (step_pending | step);
`ifdef DEMO_SEQ_BLANK_EN
            blank_cnt  <= blank_cnt_d;
            blank_q    <= blank_d;
            ret_paused <= ret_paused_d;
`endif
        end
    end

endmodule

// File: tb/tb_demo_scene_sequencer.sv
// Bench for demo_scene_sequencer: directed frame sequences followed by random
// run/pause/step/reset traffic, all compared against a frame-level reference model.
module tb_demo_scene_sequencer;

    localparam int NS  = 11;
    localparam int FPS = 3;
    localparam int BF  = 2;

    localparam int M_MANUAL = 0;
    localparam int M_PLAY   = 1;
    localparam int M_PAUSED = 2;
    localparam int M_BLANK  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_start = 1'b0;
    logic       run = 1'b0;
    logic       pause = 1'b0;
    logic       step = 1'b0;
    logic [7:0] manual_ctrl = 8'h00;
    logic [7:0] vga_control;
    logic [3:0] scene_idx;
    logic       scene_change;
    logic       blank;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state, in frame-level terms
    int m_mode, m_scene, m_shown, m_blank_seen, m_ret_mode;
    int m_vga, m_change, m_blank;
    bit m_pending;

    demo_scene_sequencer #(
        .NUM_SCENES(NS),
        .FRAMES_PER_SCENE(FPS),
        .BLANK_FRAMES(BF)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .frame_start(frame_start),
        .run(run),
        .pause(pause),
        .step(step),
        .manual_ctrl(manual_ctrl),
        .vga_control(vga_control),
        .scene_idx(scene_idx),
        .scene_change(scene_change),
        .blank(blank)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int table_entry(input int s);
        return (s % 2) * 32 + s;
    endfunction

    task automatic model_reset();
        m_mode = M_MANUAL; m_scene = 0; m_shown = 0; m_blank_seen = 0; m_ret_mode = M_PLAY;
        m_vga = 0; m_change = 0; m_blank = 0; m_pending = 0;
    endtask

    task automatic model_next_scene();
        m_scene = (m_scene + 1) % NS;
        m_shown = 0;
`ifdef DEMO_SEQ_BLANK_EN
        m_ret_mode = m_mode;
        m_mode = M_BLANK;
        m_blank = 1;
        m_blank_seen = 0;
`else
        m_vga = table_entry(m_scene);
        m_change = 1;
`endif
    endtask

    task automatic model_frame(input bit r, input bit p, input bit s, input int mc);
        bit want_step;
        want_step = m_pending || s;
        m_pending = 0;
        m_change = 0;
        if (m_mode == M_MANUAL) begin
            if (r) begin
                m_mode = M_PLAY; m_vga = table_entry(m_scene); m_shown = 0; m_change = 1;
            end else m_vga = mc;
        end else if (!r) begin
            m_mode = M_MANUAL; m_vga = mc; m_blank = 0;
        end else if (m_mode == M_BLANK) begin
            m_blank_seen++;
            if (m_blank_seen == BF) begin
                m_vga = table_entry(m_scene); m_blank = 0; m_change = 1; m_mode = m_ret_mode;
            end
        end else if (m_mode == M_PLAY) begin
            if (p) m_mode = M_PAUSED;
            else if (m_shown + 1 == FPS) model_next_scene();
            else m_shown++;
        end else begin
            if (!p) m_mode = M_PLAY;
            else if (want_step) model_next_scene();
        end
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, "_vga"}, 32'(vga_control), 32'(m_vga));
        check_val({tag, "_scene"}, 32'(scene_idx), 32'(m_scene));
        check_val({tag, "_change"}, 32'(scene_change), 32'(m_change));
        check_val({tag, "_blank"}, 32'(blank), 32'(m_blank));
    endtask

    task automatic do_frame(input bit r, input bit p, input bit s, input logic [7:0] mc);
        run = r; pause = p; step = s; manual_ctrl = mc; frame_start = 1'b1;
        model_frame(r, p, s, int'(mc));
        @(posedge clk); #1;
        frame_start = 1'b0; step = 1'b0;
        check_outputs("frame");
    endtask

    task automatic do_idle(input bit s);
        step = s;
        manual_ctrl = 8'($urandom);
        if (s) m_pending = 1;
        @(posedge clk); #1;
        step = 1'b0;
        m_change = 0;
        check_outputs("hold");
    endtask

    task automatic do_reset();
        rst_n = 1'b0; frame_start = 1'($urandom); run = 1'b1; step = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1; frame_start = 1'b0; step = 1'b0;
        model_reset();
        check_outputs("reset");
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) do_idle(1'b0);
    endtask

    initial begin
        bit r, p;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_vga", 32'(vga_control), 32'h00);
        check_val("rst_scene", 32'(scene_idx), 32'h0);
        check_val("rst_change", 32'(scene_change), 32'h0);
        check_val("rst_blank", 32'(blank), 32'h0);
        rst_n = 1'b1;
        idle_n(2);

        // manual passthrough lands at the frame boundary
        do_frame(1'b0, 1'b0, 1'b0, 8'h25);
        check_val("t1_vga", 32'(vga_control), 32'h25);
        check_val("t1_change", 32'(scene_change), 32'h0);
        idle_n(3);

        // start playing: scene 0 loads with a pulse, scene 1 after FPS frames
        do_frame(1'b1, 1'b0, 1'b0, 8'h77);
        check_val("t2_vga0", 32'(vga_control), 32'h00);
        check_val("t2_pulse0", 32'(scene_change), 32'h1);
        idle_n(2);
        for (int f = 0; f < FPS; f++) begin
            do_frame(1'b1, 1'b0, 1'b0, 8'h77);
            idle_n(2);
        end
`ifndef DEMO_SEQ_BLANK_EN
        check_val("t2_scene1", 32'(scene_idx), 32'h1);
        check_val("t2_vga1", 32'(vga_control), 32'h21);
`endif

        // free-run to the wrap from the last scene back to 0
        for (int f = 0; f < (NS - 1) * FPS; f++) begin
            do_frame(1'b1, 1'b0, 1'b0, 8'h77);
            if (f != (NS - 1) * FPS - 1) idle_n(1);
        end
`ifndef DEMO_SEQ_BLANK_EN
        check_val("t3_wrap_scene", 32'(scene_idx), 32'h0);
        check_val("t3_wrap_vga", 32'(vga_control), 32'h00);
        check_val("t3_wrap_pulse", 32'(scene_change), 32'h1);
`endif
        idle_n(2);

        // pause, step mid-frame, then a frame without step
        do_frame(1'b1, 1'b1, 1'b0, 8'h00);
        idle_n(1); do_idle(1'b1); idle_n(1);
        do_frame(1'b1, 1'b1, 1'b0, 8'h00);
        idle_n(2);
        do_frame(1'b1, 1'b1, 1'b0, 8'h00);
        idle_n(2);
        do_frame(1'b1, 1'b1, 1'b1, 8'h00);
        idle_n(2);

        // drop run mid-scene, then resume the same scene
        do_frame(1'b1, 1'b0, 1'b0, 8'h00);
        idle_n(1);
        do_frame(1'b0, 1'b0, 1'b0, 8'h03);
        check_val("t5_manual", 32'(vga_control), 32'h03);
        idle_n(2);
        do_frame(1'b1, 1'b0, 1'b0, 8'h03);
        idle_n(2);

        // random traffic
        r = 1'b1; p = 1'b0;
        for (int f = 0; f < 400; f++) begin
            if ($urandom_range(0, 59) == 0) do_reset();
            if ($urandom_range(0, 99) < 8) r = ~r;
            if ($urandom_range(0, 99) < 25) p = ~p;
            do_frame(r, p, ($urandom_range(0, 99) < 20), 8'($urandom));
            for (int g = 0; g < int'($urandom_range(1, 5)); g++)
                do_idle($urandom_range(0, 99) < 15);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
